// File: rtl/ddr2_if_ex_lfsr_seq.sv
// Write/readback sequencer for the DDR2 example driver's external LFSR pattern generator.
// Writes BEATS beats from a seeded LFSR, then reloads the seed and checks read data beat by beat.
module ddr2_if_ex_lfsr_seq #(
  parameter int               BEATS = 16,
  parameter logic [31:0]      SEED  = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       use_seed,
  input  logic [7:0] seed_in,
  input  logic       abort,
  output logic       lfsr_enable,
  output logic       lfsr_pause,
  output logic       lfsr_load,
  output logic [7:0] lfsr_ldata,
  input  logic [7:0] lfsr_data,
  output logic       wr_req,
  input  logic       wr_ready,
  output logic [7:0] wr_data,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_err
);

  typedef enum logic [2:0] {IDLE, WLOAD, WRITE, RLOAD, READ, DONE} state_t;

  localparam logic [7:0] LAST = 8'(BEATS - 1);

  state_t     state;
  logic [7:0] beat_cnt;
  logic [7:0] seed_q;
  logic       err_seen;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat_cnt  <= 8'h00;
      seed_q    <= SEED[7:0];
      err_count <= 8'h00;
      first_err <= 8'h00;
      err_seen  <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      beat_cnt  <= 8'h00;
      err_count <= 8'h00;
      first_err <= 8'h00;
      err_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WLOAD;
            seed_q    <= use_seed ? seed_in : SEED[7:0];
            beat_cnt  <= 8'h00;
            err_count <= 8'h00;
            first_err <= 8'h00;
            err_seen  <= 1'b0;
          end
        end
        WLOAD: state <= WRITE;
        WRITE: begin
          if (wr_ready) begin
            if (beat_cnt == LAST) begin
              beat_cnt <= 8'h00;
              state    <= RLOAD;
            end else begin
              beat_cnt <= beat_cnt + 8'h01;
            end
          end
        end
        RLOAD: state <= READ;
        READ: begin
          if (rd_valid) begin
            if (rd_data != lfsr_data) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'h01;
              if (!err_seen) begin
                first_err <= beat_cnt;
                err_seen  <= 1'b1;
              end
            end
            if (beat_cnt == LAST) begin
              beat_cnt <= 8'h00;
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 8'h01;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pause follows the handshake directly so the LFSR steps exactly once per accepted beat.
  always_comb begin
    lfsr_enable = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_pause  = 1'b0;
    wr_req      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      WLOAD, RLOAD: begin
        lfsr_enable = 1'b1;
        lfsr_load   = 1'b1;
        busy        = 1'b1;
      end
      WRITE: begin
        lfsr_enable = 1'b1;
        wr_req      = 1'b1;
        lfsr_pause  = !wr_ready;
        busy        = 1'b1;
      end
      READ: begin
        lfsr_enable = 1'b1;
        lfsr_pause  = !rd_valid;
        busy        = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign lfsr_ldata = seed_q;
  assign wr_data    = lfsr_data;
  assign pass       = done && (err_count == 8'h00);

endmodule

// File: tb/tb_ddr2_if_ex_lfsr_seq.sv
// Scoreboard bench for ddr2_if_ex_lfsr_seq: three instances (BEATS 4, 2, 255), each with a
// behavioural 8-bit Galois LFSR (poly 0x1D) as the external pattern generator.
module tb_ddr2_if_ex_lfsr_seq;

  localparam int NI = 3;
  localparam int BL [NI] = '{4, 2, 255};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [NI-1:0] start;
  logic          use_seed, abort, wr_ready, rd_valid;
  logic [7:0]    seed_in, rd_data;

  wire  [NI-1:0] lfsr_enable, lfsr_pause, lfsr_load, wr_req, busy, done, pass;
  wire  [7:0]    lfsr_ldata [NI];
  wire  [7:0]    lfsr_data  [NI];
  wire  [7:0]    wr_data    [NI];
  wire  [7:0]    err_count  [NI];
  wire  [7:0]    first_err  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic [7:0] first;
  } res_t;

  logic [7:0] exp_wr [$];
  res_t       exp_res [$];
  logic [7:0] seed_cur;

  function automatic logic [7:0] nxt(input logic [7:0] d);
    return {d[6:0], 1'b0} ^ (d[7] ? 8'h1D : 8'h00);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    logic [7:0] lq;

    ddr2_if_ex_lfsr_seq #(.BEATS(BL[g]), .SEED(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start[g]), .use_seed(use_seed),
      .seed_in(seed_in), .abort(abort), .lfsr_enable(lfsr_enable[g]),
      .lfsr_pause(lfsr_pause[g]), .lfsr_load(lfsr_load[g]), .lfsr_ldata(lfsr_ldata[g]),
      .lfsr_data(lfsr_data[g]), .wr_req(wr_req[g]), .wr_ready(wr_ready),
      .wr_data(wr_data[g]), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy[g]),
      .done(done[g]), .pass(pass[g]), .err_count(err_count[g]), .first_err(first_err[g])
    );

    always_ff @(posedge clk) begin
      if (!lfsr_enable[g] || lfsr_load[g]) lq <= lfsr_ldata[g];
      else if (!lfsr_pause[g])             lq <= nxt(lq);
    end
    assign lfsr_data[g] = lq;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops write beats on every accepted transfer and results when done rises.
  initial begin
    logic [NI-1:0] dq;
    logic [7:0]    e;
    res_t          r;
    dq = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (wr_req[g] === 1'b1 && wr_ready === 1'b1) begin
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_extra[%0d]: got 0x%0h expected no beat", g, wr_data[g]);
          end else begin
            e = exp_wr.pop_front();
            chk($sformatf("wr_data[%0d]", g), wr_data[g], e);
          end
        end
        if (done[g] === 1'b1 && dq[g] !== 1'b1) begin
          if (exp_res.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_extra[%0d]: got done expected none", g);
          end else begin
            r = exp_res.pop_front();
            chk($sformatf("pass[%0d]", g), pass[g], r.pass);
            chk($sformatf("err_count[%0d]", g), err_count[g], r.err);
            chk($sformatf("first_err[%0d]", g), first_err[g], r.first);
          end
        end
      end
      dq = done;
    end
  end

  task automatic chk_idle(input int g, input logic [7:0] ld, input string tag);
    chk({tag, "_busy"}, busy[g], 0);
    chk({tag, "_done"}, done[g], 0);
    chk({tag, "_pass"}, pass[g], 0);
    chk({tag, "_ctl"}, {lfsr_enable[g], lfsr_load[g], lfsr_pause[g], wr_req[g]}, 0);
    chk({tag, "_err"}, err_count[g], 0);
    chk({tag, "_first"}, first_err[g], 0);
    chk({tag, "_ldata"}, lfsr_ldata[g], ld);
  endtask

  task automatic start_run(input int g, input logic us, input logic [7:0] sd);
    logic [7:0] d;
    seed_cur = us ? sd : 8'h20;
    d = seed_cur;
    for (int i = 0; i < BL[g]; i++) begin
      exp_wr.push_back(d);
      d = nxt(d);
    end
    use_seed = us; seed_in = sd; start[g] = 1'b1;
    tick;
    start[g] = 1'b0; use_seed = 1'b0; seed_in = 8'h00;
    chk("wload_load", {busy[g], lfsr_load[g]}, 2'b11);
  endtask

  // Runs WRITE until the sequencer reaches RLOAD; noise drives rd_valid that must be ignored.
  task automatic write_phase(input int g, input bit stall, input bit noise, input bit poke);
    int cyc;
    bit wrote;
    cyc = 0; wrote = 0;
    wr_ready = 1'b1; rd_valid = noise; rd_data = 8'h55;
    forever begin
      tick;
      cyc++;
      if (lfsr_load[g] && wrote) break;
      if (wr_req[g]) wrote = 1;
      if (poke && cyc == 3) begin
        start[g] = 1'b1; use_seed = 1'b1; seed_in = 8'h80;
      end else begin
        start[g] = 1'b0; use_seed = 1'b0; seed_in = 8'h00;
      end
      if (stall) wr_ready = ~wr_ready;
      if (cyc > 2000) begin
        chk("wr_timeout", cyc, 0);
        break;
      end
    end
    wr_ready = 1'b1;
  endtask

  task automatic read_beats(input int g, input int cnt, input bit gaps, input int mode);
    logic [7:0] d;
    d = seed_cur;
    tick;
    for (int b = 0; b < cnt; b++) begin
      if (gaps && (b % 2 == 1)) begin
        rd_valid = 1'b0; rd_data = 8'hA5;
        tick;
      end
      rd_valid = 1'b1;
      case (mode)
        1:       rd_data = (b == 1) ? 8'h00 : d;
        2:       rd_data = ~d;
        default: rd_data = d;
      endcase
      tick;
      d = nxt(d);
    end
    rd_valid = 1'b0;
  endtask

  task automatic run(input int g, input logic us, input logic [7:0] sd, input bit stall,
                     input bit gaps, input int mode, input bit poke);
    res_t r;
    int   n;
    n = BL[g];
    case (mode)
      1:       r = '{pass: 1'b0, err: 8'd1, first: 8'd1};
      2:       r = '{pass: 1'b0, err: (n > 255) ? 8'd255 : 8'(n), first: 8'd0};
      default: r = '{pass: 1'b1, err: 8'd0, first: 8'd0};
    endcase
    exp_res.push_back(r);
    start_run(g, us, sd);
    write_phase(g, stall, gaps, poke);
    read_beats(g, n, gaps, mode);
    chk("done_after_read", {done[g], busy[g]}, 2'b10);
    tick;
    tick;
  endtask

  initial begin
    reset_n = 1'b0; start = '0; use_seed = 1'b0; seed_in = 8'h00; abort = 1'b0;
    wr_ready = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_idle(0, 8'h20, "rst");

    // Default seed, full-rate, start poked mid-write must be ignored
    run(0, 1'b0, 8'h00, 0, 0, 0, 1);
    // Stalled writes, gapped reads, rd_valid noise outside READ
    run(0, 1'b0, 8'h00, 1, 1, 0, 0);
    // Custom seed 0x80, beat 1 corrupted
    run(1, 1'b1, 8'h80, 0, 0, 1, 0);
    // 255 beats all wrong: saturating count
    run(2, 1'b0, 8'h00, 0, 0, 2, 0);

    // Abort in READ after two wrong beats
    start_run(0, 1'b0, 8'h00);
    write_phase(0, 0, 0, 0);
    read_beats(0, 2, 0, 2);
    chk("pre_abort_err", err_count[0], 2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_err", err_count[0], 0);
    chk("abort_state", {done[0], lfsr_enable[0]}, 0);
    run(0, 1'b0, 8'h00, 0, 0, 0, 0);

    // Reset mid-write with a custom seed loaded
    start_run(0, 1'b1, 8'h80);
    tick;
    tick;
    chk("pre_rst_wr", wr_req[0], 1);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    exp_wr.delete();
    chk_idle(0, 8'h20, "midrst");
    run(0, 1'b0, 8'h00, 0, 0, 0, 0);

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("res_queue_drained", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
